uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-flop rxd synchroniser, free-running oversampling tick, frame FSM,
// and a one-word holding register with parity, frame, overrun and break reporting.
// state   | meaning
// IDLE    | line idle, waiting for a low sample
// START   | qualifying the start bit at its midpoint
// DATA    | shifting in data bits, LSB first
// PAR     | sampling the parity bit
// STOP    | sampling stop bit(s)
// WAIT_HI | stop bit was low, holding off until the line returns high
module uart_rx_cfg #(
  parameter int CLK_DIV    = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int DVW = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF_TC  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]  FULL_TC  = CW'(OVERSAMPLE - 1);
  localparam logic [DVW-1:0] DIV_LOAD = DVW'(CLK_DIV - 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HI
  } state_e;

  logic                 sync1_q, sync2_q;
  logic [DVW-1:0]       div_q, div_d;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 brk_q, brk_d;

  logic rx_s, tick, sample, frame_end;
  logic first_stop_low, par_zero, is_break, perr_new, ferr_new, load;

  assign rx_s   = sync2_q;
  assign tick   = (div_q == '0);
  assign sample = tick && (cnt_q == FULL_TC);

  always_comb begin
    div_d      = tick ? DIV_LOAD : div_q - 1'b1;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    frame_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick && !rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_TC) begin
            if (!rx_s) begin
              state_d = S_DATA;
              cnt_d   = '0;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      S_DATA: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (sample) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT) begin
            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
            stop_idx_d = 1'b0;
            ferr_acc_d = 1'b0;
          end
        end
      end
      S_PAR: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (sample) begin
          par_d   = rx_s;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (sample) begin
          if (!rx_s) ferr_acc_d = 1'b1;
          if (stop_idx_q == LAST_STOP) begin
            frame_end = 1'b1;
            state_d   = rx_s ? S_IDLE : S_WAIT_HI;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      S_WAIT_HI: begin
        if (tick && rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With two stop bits the accumulated error flag is exactly "first stop was low".
  always_comb begin
    first_stop_low = (STOP_BITS == 2) ? ferr_acc_q : ~rx_s;
    par_zero       = (PARITY == 0) ? 1'b1 : ~par_q;
    is_break       = (shift_q == '0) && par_zero && first_stop_low;
    ferr_new       = ferr_acc_q | ~rx_s;
    case (PARITY)
      1:       perr_new = ^shift_q ^ par_q;
      2:       perr_new = ~(^shift_q ^ par_q);
      default: perr_new = 1'b0;
    endcase
    load = frame_end && !is_break && (!valid_q || rx_ready);

    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = valid_q;
    if (load) begin
      rx_data_d = shift_q;
      perr_d    = perr_new;
      ferr_d    = ferr_new;
      valid_d   = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
    ovr_d = frame_end && !is_break && valid_q && !rx_ready;
    brk_d = frame_end && is_break;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      div_q      <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      rx_data_q  <= rx_data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
  assign break_det   = brk_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8E1, 8N1, 8N2) driven by a frame generator,
// a directed vector table, randomized frames against a frame-level model, and corner sequences.
module tb_uart_rx_cfg;

  localparam int BIT = 64;  // clk cycles per bit: CLK_DIV(4) * OVERSAMPLE(16)

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rxd_v;
  logic [2:0] ready_v;
  logic [7:0] data_w [3];
  logic [2:0] valid_w, perr_w, ferr_w, ovr_w, brk_w, busy_w;

  int vectors = 0;
  int errors  = 0;
  int ovr_cnt [3] = '{0, 0, 0};
  int brk_cnt [3] = '{0, 0, 0};
  int exp_ovr [3] = '{0, 0, 0};
  int exp_brk [3] = '{0, 0, 0};
  logic       m_valid [3];
  logic [7:0] m_data  [3];
  logic       m_pe    [3];
  logic       m_fe    [3];

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_v[0]), .rx_data(data_w[0]), .rx_valid(valid_w[0]),
    .rx_ready(ready_v[0]), .parity_err(perr_w[0]), .frame_err(ferr_w[0]),
    .overrun_err(ovr_w[0]), .break_det(brk_w[0]), .busy(busy_w[0]));

  uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_v[1]), .rx_data(data_w[1]), .rx_valid(valid_w[1]),
    .rx_ready(ready_v[1]), .parity_err(perr_w[1]), .frame_err(ferr_w[1]),
    .overrun_err(ovr_w[1]), .break_det(brk_w[1]), .busy(busy_w[1]));

  uart_rx_cfg #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_v[2]), .rx_data(data_w[2]), .rx_valid(valid_w[2]),
    .rx_ready(ready_v[2]), .parity_err(perr_w[2]), .frame_err(ferr_w[2]),
    .overrun_err(ovr_w[2]), .break_det(brk_w[2]), .busy(busy_w[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ovr_w[i]) ovr_cnt[i]++;
      if (brk_w[i]) brk_cnt[i]++;
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       ev;
    logic [7:0] ed;
    logic       epe;
    logic       efe;
    int         dovr;
    int         dbrk;
    logic       consume;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int inst, input logic [7:0] d, input logic has_par,
                            input logic p, input int nstop, input logic s0, input logic s1,
                            input logic hold_low);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(p);
    bits.push_back(s0);
    if (nstop == 2) bits.push_back(s1);
    foreach (bits[k]) begin
      rxd_v[inst] = bits[k];
      wait_neg(BIT);
    end
    rxd_v[inst] = ~hold_low;
    wait_neg(BIT);
  endtask

  // Frame-level reference: what a receiver must report for one complete frame (even parity).
  task automatic model_frame(input int inst, input logic [7:0] d, input logic has_par,
                             input logic p, input int nstop, input logic s0, input logic s1);
    logic brk;
    brk = (d == 8'h00) && (!has_par || !p) && !s0;
    if (brk) exp_brk[inst]++;
    else if (m_valid[inst]) exp_ovr[inst]++;
    else begin
      m_valid[inst] = 1'b1;
      m_data[inst]  = d;
      m_pe[inst]    = has_par ? (p != ^d) : 1'b0;
      m_fe[inst]    = !s0 || (nstop == 2 && !s1);
    end
  endtask

  task automatic check_state(input int inst, input string tag, input logic ev,
                             input logic [7:0] ed, input logic epe, input logic efe);
    chk({tag, ".valid"},   32'(valid_w[inst]), 32'(ev));
    chk({tag, ".data"},    32'(data_w[inst]),  32'(ed));
    chk({tag, ".perr"},    32'(perr_w[inst]),  32'(epe));
    chk({tag, ".ferr"},    32'(ferr_w[inst]),  32'(efe));
    chk({tag, ".overrun"}, 32'(ovr_cnt[inst]), 32'(exp_ovr[inst]));
    chk({tag, ".break"},   32'(brk_cnt[inst]), 32'(exp_brk[inst]));
  endtask

  task automatic check_model(input int inst, input string tag);
    check_state(inst, tag, m_valid[inst], m_data[inst], m_pe[inst], m_fe[inst]);
  endtask

  task automatic consume(input int inst, input string tag);
    ready_v[inst] = 1'b1;
    wait_neg(1);
    ready_v[inst] = 1'b0;
    m_valid[inst] = 1'b0;
    chk({tag, ".consumed"}, 32'(valid_w[inst]), 32'(0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 8'h00;
      m_pe[i]    = 1'b0;
      m_fe[i]    = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         r;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 0, 0, 1'b1};
    tbl[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1, 0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 0, 0, 1'b1};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 1, 1'b0};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 1'b1};
    tbl[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 0, 1'b0};
    tbl[7] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 0, 1, 1'b1};

    rst_n   = 1'b0;
    rxd_v   = 3'b111;
    ready_v = 3'b000;
    model_reset();
    wait_neg(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d.valid", i), 32'(valid_w[i]), 32'(0));
      chk($sformatf("reset%0d.data", i),  32'(data_w[i]),  32'(0));
      chk($sformatf("reset%0d.busy", i),  32'(busy_w[i]),  32'(0));
      chk($sformatf("reset%0d.flags", i),
          32'({perr_w[i], ferr_w[i], ovr_w[i], brk_w[i]}), 32'(0));
    end
    rst_n = 1'b1;
    wait_neg(8);

    // directed table on the 8E1 instance
    for (int v = 0; v < 8; v++) begin
      send_frame(0, tbl[v].d, 1'b1, tbl[v].p, 1, tbl[v].s, 1'b1, 1'b0);
      exp_ovr[0] += tbl[v].dovr;
      exp_brk[0] += tbl[v].dbrk;
      check_state(0, $sformatf("tbl%0d", v), tbl[v].ev, tbl[v].ed, tbl[v].epe, tbl[v].efe);
      if (tbl[v].consume) consume(0, $sformatf("tbl%0d", v));
    end
    m_valid[0] = 1'b0;
    m_data[0]  = 8'hFF;
    m_pe[0]    = 1'b0;
    m_fe[0]    = 1'b0;

    // randomized frames on the 8E1 instance
    for (int n = 0; n < 25; n++) begin
      d = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      p = (r == 1) ? ~(^d) : ^d;
      s = (r == 2 || r == 3) ? 1'b0 : 1'b1;
      if (r == 0) begin
        d = 8'h00;
        p = 1'b0;
        s = 1'b0;
      end
      send_frame(0, d, 1'b1, p, 1, s, 1'b1, 1'b0);
      model_frame(0, d, 1'b1, p, 1, s, 1'b1);
      check_model(0, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) consume(0, $sformatf("rnd%0d", n));
    end

    // 8N1: no-parity build never flags parity
    send_frame(1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    model_frame(1, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check_model(1, "n1_01");
    consume(1, "n1_01");

    // overrun: second word dropped while first is held
    send_frame(1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    model_frame(1, 8'h11, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    send_frame(1, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    model_frame(1, 8'h22, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check_state(1, "ovr", 1'b1, 8'h11, 1'b0, 1'b0);
    consume(1, "ovr");

    // false start: low for 3 ticks only
    rxd_v[1] = 1'b0;
    wait_neg(12);
    chk("glitch.busy_high", 32'(busy_w[1]), 32'(1));
    rxd_v[1] = 1'b1;
    wait_neg(2 * BIT);
    chk("glitch.busy_low", 32'(busy_w[1]), 32'(0));
    check_model(1, "glitch");

    // line break: low for 12 bit times
    rxd_v[1] = 1'b0;
    wait_neg(12 * BIT);
    exp_brk[1]++;
    chk("brk.busy_high", 32'(busy_w[1]), 32'(1));
    check_model(1, "brk");
    rxd_v[1] = 1'b1;
    wait_neg(BIT);
    chk("brk.busy_low", 32'(busy_w[1]), 32'(0));

    // 8N2: low second stop bit, FSM holds until the line goes high
    send_frame(2, 8'h96, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    model_frame(2, 8'h96, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    check_model(2, "n2_stop");
    wait_neg(2 * BIT);
    chk("n2_wait.busy_high", 32'(busy_w[2]), 32'(1));
    rxd_v[2] = 1'b1;
    wait_neg(BIT);
    chk("n2_wait.busy_low", 32'(busy_w[2]), 32'(0));

    // reset in the middle of data bit 3, with a word already held
    send_frame(1, 8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    model_frame(1, 8'h5A, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check_model(1, "pre_rst");
    d = 8'h3C;
    rxd_v[1] = 1'b0;
    wait_neg(BIT);
    for (int i = 0; i < 3; i++) begin
      rxd_v[1] = d[i];
      wait_neg(BIT);
    end
    rxd_v[1] = d[3];
    wait_neg(BIT / 2);
    chk("mid_rst.busy_before", 32'(busy_w[1]), 32'(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst.valid", 32'(valid_w[1]), 32'(0));
    chk("mid_rst.data",  32'(data_w[1]),  32'(0));
    chk("mid_rst.busy",  32'(busy_w[1]),  32'(0));
    chk("mid_rst.flags", 32'({perr_w[1], ferr_w[1], ovr_w[1], brk_w[1]}), 32'(0));
    rxd_v[1] = 1'b1;
    wait_neg(BIT);
    rst_n = 1'b1;
    wait_neg(BIT);
    send_frame(1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
    model_frame(1, 8'h3C, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    check_model(1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
